// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// Each rx_data_valid strobe writes one byte into a circular register FIFO.
// The host reads through a first-word-fall-through valid/ready port.
// A dropped byte sets a sticky overflow flag, so loss is never silent.
// Optional feature: define UART_RXF_ALMOST_FULL_EN to add a registered
// almost_full output, asserted while count >= AF_THRESH.
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_THRESH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_data_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overflow,
  input  logic                  overflow_clr
`ifdef UART_RXF_ALMOST_FULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam int                  CNT_W   = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  pop, push_ok, drop;

  // Status decodes come only from registered count, never from inputs.
  assign rd_valid = (count_q != '0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign overflow = overflow_q;
  // Head entry is read combinationally (FWFT); zeroed while empty.
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign pop     = rd_valid & rd_ready;
  assign push_ok = rx_data_valid & (~full | pop);
  assign drop    = rx_data_valid & full & ~pop;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Drop wins over clear so a loss in the clear cycle is not hidden.
    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  // Control state; async reset discards all contents immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_data;
  end

`ifdef UART_RXF_ALMOST_FULL_EN
  localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_THRESH);
  logic almost_full_q;

  // Registered threshold flag, updated on the same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) almost_full_q <= 1'b0;
    else        almost_full_q <= (count_d >= AF_C);
  end

  assign almost_full = almost_full_q;
`else
  // Threshold only matters when the almost-full output is built.
  logic unused_af_thresh;
  assign unused_af_thresh = (AF_THRESH != 0);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of per-cycle vectors plus
// hand-written sequences for reset behaviour.
module tb_uart_rx_fifo;
  localparam int DATA_W = 8;
  localparam int DL2    = 4;
  localparam int AF     = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic             rx_data_valid = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [DL2:0]     count;
  logic             full;
  logic             overflow;
  logic             overflow_clr = 1'b0;
`ifdef UART_RXF_ALMOST_FULL_EN
  logic             almost_full;
`endif

  uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DL2), .AF_THRESH(AF)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .count(count),
    .full(full), .overflow(overflow), .overflow_clr(overflow_clr)
`ifdef UART_RXF_ALMOST_FULL_EN
    , .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] din;
    logic       rdy;
    logic       clr;
    logic       e_vld;
    logic [7:0] e_data;
    int         e_cnt;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic [7:0] din, input logic rdy,
                     input logic clr, input logic ev, input logic [7:0] ed,
                     input int ec, input logic ef, input logic eo);
    vec_t v;
    v.vld = vld; v.din = din; v.rdy = rdy; v.clr = clr;
    v.e_vld = ev; v.e_data = ed; v.e_cnt = ec; v.e_full = ef; v.e_ovf = eo;
    vecs.push_back(v);
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic [7:0] ed,
                          input int ec, input logic ef, input logic eo);
    chk({tag, " rd_valid"}, int'(rd_valid), int'(ev));
    chk({tag, " rd_data"},  int'(rd_data),  int'(ed));
    chk({tag, " count"},    int'(count),    ec);
    chk({tag, " full"},     int'(full),     int'(ef));
    chk({tag, " overflow"}, int'(overflow), int'(eo));
`ifdef UART_RXF_ALMOST_FULL_EN
    chk({tag, " almost_full"}, int'(almost_full), int'(ec >= AF));
`endif
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic vld, input logic [7:0] din, input logic rdy,
                      input logic clr);
    rx_data_valid = vld; rx_data = din; rd_ready = rdy; overflow_clr = clr;
    @(posedge clk);
    #1;
    rx_data_valid = 1'b0; rd_ready = 1'b0; overflow_clr = 1'b0;
  endtask

  initial begin
    // Single byte in and out, then rd_ready on an empty FIFO.
    add(1, 8'hA5, 0, 0,  1, 8'hA5, 1, 0, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0);
    // Fill 0x01..0x10; head stays 0x01.
    for (int i = 1; i <= 16; i++)
      add(1, 8'(i), 0, 0,  1, 8'h01, i, (i == 16), 0);
    // Drop while full; then drop and clear together; then plain clear.
    add(1, 8'h77, 0, 0,  1, 8'h01, 16, 1, 1);
    add(1, 8'h78, 0, 1,  1, 8'h01, 16, 1, 1);
    add(0, 8'h00, 0, 1,  1, 8'h01, 16, 1, 0);
    // Full with simultaneous push and pop: 0x01 out, 0x55 in.
    add(1, 8'h55, 1, 0,  1, 8'h02, 16, 1, 0);
    // Drain: 0x03..0x10, then 0x55 as the last head, then empty.
    for (int k = 1; k <= 16; k++) begin
      if (k <= 14)      add(0, 8'h00, 1, 0,  1, 8'(k + 2), 16 - k, 0, 0);
      else if (k == 15) add(0, 8'h00, 1, 0,  1, 8'h55, 1, 0, 0);
      else              add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0);
    end
    // Second pass with pointers starting mid-array (wrap check).
    for (int i = 1; i <= 16; i++)
      add(1, 8'(8'h80 + i), 0, 0,  1, 8'h81, i, (i == 16), 0);
    // Non-empty push+pop keeps count; then drain.
    add(1, 8'hEE, 1, 0,  1, 8'h82, 16, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      if (k <= 14)      add(0, 8'h00, 1, 0,  1, 8'(8'h82 + k), 16 - k, 0, 0);
      else if (k == 15) add(0, 8'h00, 1, 0,  1, 8'hEE, 1, 0, 0);
      else              add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0);
    end

    // Reset state while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Before the first edge the FIFO is still empty.
    rx_data_valid = 1'b1; rx_data = 8'hA5;
    #1;
    chk("pre-edge rd_valid", int'(rd_valid), 0);

    foreach (vecs[i]) begin
      step(vecs[i].vld, vecs[i].din, vecs[i].rdy, vecs[i].clr);
      chk_outs($sformatf("v%0d", i), vecs[i].e_vld, vecs[i].e_data,
               vecs[i].e_cnt, vecs[i].e_full, vecs[i].e_ovf);
    end

    // Mid-stream async reset with overflow set: everything clears at once.
    for (int i = 0; i < 17; i++) step(1, 8'(8'h40 + i), 0, 0);
    chk_outs("pre-rst", 1, 8'h40, 16, 1, 1);
    rst_n = 1'b0;
    #1;
    chk_outs("async-rst", 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'hC3, 0, 0);
    step(1, 8'hC4, 0, 0);
    chk_outs("post-rst", 1, 8'hC3, 2, 0, 0);
    step(0, 8'h00, 1, 0);
    chk_outs("post-rst pop", 1, 8'hC4, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each received byte, which arrives as a single-cycle rx_data_valid strobe, into a synchronous circular FIFO. Bytes are presented to the host/bus side through a first-word-fall-through valid/ready interface. Overflow is detected and reported with a sticky flag, so bytes are never silently lost.

Parameters:
DATA_W, 8, byte width; matches the receiver data width.
DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 (default 16 entries); legal range 2..8.
AF_THRESH, 12, almost-full threshold in entries; used only when UART_RXF_ALMOST_FULL_EN is defined; legal range 1..2**DEPTH_LOG2.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  asynchronous reset, active-low.
rx_data  in  DATA_W  received byte from the receiver; sampled only when rx_data_valid=1.
rx_data_valid  in  1  write strobe; one clk wide per received byte.
rd_data  out  DATA_W  head-of-FIFO byte; forced to 0 when empty.
rd_valid  out  1  FIFO non-empty; rd_data is valid.
rd_ready  in  1  consumer accepts rd_data this cycle.
count  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
full  out  1  count == 2**DEPTH_LOG2.
overflow  out  1  sticky flag: a byte was dropped.
overflow_clr  in  1  synchronous clear of overflow.
almost_full  out  1  present only with UART_RXF_ALMOST_FULL_EN.

Behaviour:
- Reset (async assert, sync-to-clk release): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Resulting outputs: rd_valid=0, full=0, rd_data=0, almost_full=0. Storage array is not reset. Reset mid-operation discards all contents immediately.
- Storage: 2**DEPTH_LOG2 x DATA_W register array. wr_ptr and rd_ptr are DEPTH_LOG2 bits and wrap naturally from max to 0. count is a separate registered occupancy counter.
- pop = rd_valid & rd_ready. pop has no effect when empty (rd_valid=0).
- push_req = rx_data_valid.
- push_ok = push_req & (!full | pop). When full, a simultaneous pop frees a slot, so the write is accepted.
- On push_ok: mem[wr_ptr] <= rx_data; wr_ptr += 1.
- On pop: rd_ptr += 1.
- count next value: +1 if push_ok & !pop; -1 if pop & !push_ok; otherwise unchanged.
- rd_valid = (count != 0); full = (count == 2**DEPTH_LOG2). Both are decoded from registered count with no combinational path from inputs.
- rd_data = rd_valid ? mem[rd_ptr] : 0. Combinational read of the head entry (FWFT).
- Latency: a byte strobed at clk edge N is visible on rd_data/rd_valid after edge N; one-cycle write-to-read latency.
- Empty + push in the same cycle: no pop can occur (rd_valid=0). The byte appears the next cycle.
- Non-empty + push + pop: both occur and count is unchanged.
- Overflow: push_req & full & !pop drops the byte, leaves pointers and count unchanged, and sets overflow=1 at the next edge.
- overflow_clr=1 clears overflow at the next edge. If a drop occurs in the same cycle as overflow_clr, set wins and overflow stays 1.
- rd_ready asserted while rd_valid=0 is ignored.
- Ordering: strict FIFO. Byte order out equals strobe order in, excluding dropped bytes.

Optional Feature:
UART_RXF_ALMOST_FULL_EN
- Defined: port almost_full exists and is registered. It equals 1 in any cycle where count >= AF_THRESH (decoded from registered count, so it updates on the same edge as count). Reset value is 0. Host flow-control logic uses it.
- Not defined: port almost_full and its logic are absent. AF_THRESH is unused. All other behaviour is identical.

Test Plan:
- Reset then strobe 0xA5: rd_valid=0 before the edge; after it, rd_valid=1, rd_data=0xA5, count=1. Pulse rd_ready for one cycle: rd_valid=0, rd_data=0, count=0.
- Strobe 0x01..0x10 (16 bytes) with rd_ready=0: full=1, count=16. Then drain with rd_ready=1: 0x01..0x10 emerge in order, one per cycle; empty afterwards. Pointers wrap cleanly on a second fill/drain pass.
- Fill to 16, then strobe 0x77 with rd_ready=0: byte dropped, overflow=1, count stays 16, head still 0x01. Then overflow_clr=1: overflow=0 next cycle. Drop and clr in the same cycle: overflow stays 1.
- Full, then strobe 0x55 with rd_ready=1 in the same cycle: 0x01 popped, 0x55 accepted, count stays 16, overflow=0. The 16th byte read is 0x55.
- Load 5 bytes, assert rst_n=0 mid-stream: rd_valid=0, count=0, overflow=0, rd_data=0 immediately. After release, the first new byte strobed is the first read.
- With UART_RXF_ALMOST_FULL_EN and AF_THRESH=12: almost_full=0 at count 11, rises the cycle count reaches 12, and falls when one pop brings count back to 11. Build without the macro: the port is absent and the other scenarios still pass.
